// File: rtl/ic_pkg.sv
// Shared definitions for the interconnect port arbiter: requester IDs,
// arbiter state encoding and the round-robin winner helper.
package ic_pkg;

    localparam logic IC_ID_IMEM = 1'b0;
    localparam logic IC_ID_DMEM = 1'b1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    // On contention the requester that did not win last time takes the port.
    function automatic logic ic_pick_rr(input logic m0_req, input logic m1_req,
                                        input logic last_id);
        if (m0_req && m1_req) begin
            return ~last_id;
        end
        return m1_req ? IC_ID_DMEM : IC_ID_IMEM;
    endfunction

endpackage

// File: rtl/ic_arb_order_fifo.sv
// In-order FIFO of requester IDs for accepted requests; the head entry
// names the owner of the next response from the target.
module ic_arb_order_fifo
    import ic_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= 1'b0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ic_port_arbiter.sv
// Two-requester (imem/dmem) arbiter onto one target port with in-order
// response routing. Define IC_ARB_RR_EN for round-robin, else m1 wins.
module ic_port_arbiter
    import ic_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        m0_req,
    input  logic        m0_wen,
    input  logic [3:0]  m0_strb,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m0_addr,
    output logic        m0_gnt,
    output logic        m0_recv,
    input  logic        m0_ack,
    output logic        m0_error,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_wen,
    input  logic [3:0]  m1_strb,
    input  logic [31:0] m1_wdata,
    input  logic [31:0] m1_addr,
    output logic        m1_gnt,
    output logic        m1_recv,
    input  logic        m1_ack,
    output logic        m1_error,
    output logic [31:0] m1_rdata,

    output logic        p_req,
    output logic        p_wen,
    output logic [3:0]  p_strb,
    output logic [31:0] p_wdata,
    output logic [31:0] p_addr,
    input  logic        p_gnt,
    input  logic        p_recv,
    output logic        p_ack,
    input  logic        p_error,
    input  logic [31:0] p_rdata
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       sel_q;
    logic       sel_d;
    logic       cur_sel;
    logic       sel_req;
    logic       win_id;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       head_id;
    logic       resp_live;

`ifdef IC_ARB_RR_EN
    logic last_q;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            last_q <= IC_ID_DMEM;
        end else if (push) begin
            last_q <= cur_sel;
        end
    end

    assign win_id = ic_pick_rr(m0_req, m1_req, last_q);
`else
    assign win_id = m1_req ? IC_ID_DMEM : IC_ID_IMEM;
`endif

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= ARB_IDLE;
            sel_q   <= IC_ID_IMEM;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // HOLD is left either on the grant or when the frozen requester withdraws.
    always_comb begin
        state_d = state_q;
        sel_d   = cur_sel;
        case (state_q)
            ARB_IDLE: if (p_req && !p_gnt) state_d = ARB_HOLD;
            ARB_HOLD: if (!sel_req || (p_req && p_gnt)) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        cur_sel   = (state_q == ARB_HOLD) ? sel_q : win_id;
        sel_req   = (cur_sel == IC_ID_DMEM) ? m1_req : m0_req;
        p_req     = g_resetn && sel_req && !fifo_full;
        p_wen     = 1'b0;
        p_strb    = '0;
        p_wdata   = '0;
        p_addr    = '0;
        if (g_resetn) begin
            p_wen   = (cur_sel == IC_ID_DMEM) ? m1_wen   : m0_wen;
            p_strb  = (cur_sel == IC_ID_DMEM) ? m1_strb  : m0_strb;
            p_wdata = (cur_sel == IC_ID_DMEM) ? m1_wdata : m0_wdata;
            p_addr  = (cur_sel == IC_ID_DMEM) ? m1_addr  : m0_addr;
        end
        m0_gnt    = p_req && p_gnt && (cur_sel == IC_ID_IMEM);
        m1_gnt    = p_req && p_gnt && (cur_sel == IC_ID_DMEM);

        resp_live = g_resetn && !fifo_empty;
        m0_recv   = p_recv  && resp_live && (head_id == IC_ID_IMEM);
        m1_recv   = p_recv  && resp_live && (head_id == IC_ID_DMEM);
        m0_error  = p_error && m0_recv;
        m1_error  = p_error && m1_recv;
        m0_rdata  = (resp_live && head_id == IC_ID_IMEM) ? p_rdata : '0;
        m1_rdata  = (resp_live && head_id == IC_ID_DMEM) ? p_rdata : '0;
        p_ack     = resp_live && ((head_id == IC_ID_DMEM) ? m1_ack : m0_ack);
    end

    assign push = p_req && p_gnt;
    assign pop  = p_recv && p_ack;

    ic_arb_order_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk     (g_clk),
        .rst_n   (g_resetn),
        .push    (push),
        .push_id (cur_sel),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head_id)
    );

endmodule
